// File: rtl/hs_pkg.sv
// Shared definitions for the 4-phase send/ack link: FSM state codes and counter width.
package hs_pkg;

   localparam int WCNT_W = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      REQ      = 3'd2,
      WAIT_REL = 3'd3,
      ERR      = 3'd4
   } state_t;

endpackage

// File: rtl/hs_sync_fifo.sv
// Small synchronous FIFO with combinational head read; pointers carry an extra wrap bit
// so full and empty are told apart without a separate count.
module hs_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wptr;
   logic [AW:0]       rptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: empty pointers make stale contents unobservable.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/hs4_sender.sv
// Source side of the 4-phase send/ack link: queues words and drains them one handshake at a time.
// Optional ack timeout is built when HS_TIMEOUT_EN is defined.
//
//   state    | meaning
//   IDLE     | wait for a queued word and ack low
//   LOAD     | pop head into dados, raise send
//   REQ      | send high, wait for ack rise
//   WAIT_REL | send low, wait for ack fall, count the word
//   ERR      | ack timeout; sticky until rst
module hs4_sender
   import hs_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              send,
   output logic [DATA_W-1:0] dados,
   input  logic              ack,
   output logic [2:0]        estado,
   output logic [WCNT_W-1:0] words_sent,
   output logic              err
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_check
      $error("hs4_sender: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 2");
   end

   state_t            state;
   state_t            state_nxt;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              inc;
   logic [DATA_W-1:0] head;

   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   assign estado   = state;

   hs_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef HS_TIMEOUT_EN
   localparam int PW = $clog2(TIMEOUT_CYC) + 1;

   logic [PW-1:0] phase_cnt;
   logic          phase_exp;

   assign phase_exp = (phase_cnt == PW'(TIMEOUT_CYC - 1));

   // Restarts on every state change, so it clears on entry to both REQ and WAIT_REL.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_cnt <= '0;
      end else if (state_nxt != state) begin
         phase_cnt <= '0;
      end else if (state == REQ || state == WAIT_REL) begin
         phase_cnt <= phase_cnt + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) err <= 1'b0;
      else if (state_nxt == ERR) err <= 1'b1;
   end
`else
   logic phase_exp;

   assign phase_exp = 1'b0;
   assign err       = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      inc       = 1'b0;
      case (state)
         IDLE: begin
            // A stale ack (e.g. left over from reset) holds us here.
            if (!fifo_empty && !ack) state_nxt = LOAD;
         end
         LOAD: begin
            pop       = 1'b1;
            state_nxt = REQ;
         end
         REQ: begin
            if (ack)            state_nxt = WAIT_REL;
            else if (phase_exp) state_nxt = ERR;
         end
         WAIT_REL: begin
            if (!ack) begin
               inc       = 1'b1;
               state_nxt = IDLE;
            end else if (phase_exp) begin
               state_nxt = ERR;
            end
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         send       <= 1'b0;
         dados      <= '0;
         words_sent <= '0;
      end else begin
         state <= state_nxt;
         send  <= (state_nxt == REQ);
         if (pop) dados      <= head;
         if (inc) words_sent <= words_sent + WCNT_W'(1);
      end
   end

endmodule
